// File: rtl/error_corrector.sv
// Final RS(204,188) stage: buffers one codeword, applies the located error
// magnitudes and streams the corrected bytes out through a two-entry skid.
module error_corrector #(
    parameter int N  = 204,
    parameter int T  = 8,
    parameter int AW = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    input  logic       corr_valid,
    input  logic       corr_fail,
    input  logic [7:0] el1,
    input  logic [7:0] el2,
    input  logic [7:0] el3,
    input  logic [7:0] el4,
    input  logic [7:0] el5,
    input  logic [7:0] el6,
    input  logic [7:0] el7,
    input  logic [7:0] el8,
    input  logic [7:0] em1,
    input  logic [7:0] em2,
    input  logic [7:0] em3,
    input  logic [7:0] em4,
    input  logic [7:0] em5,
    input  logic [7:0] em6,
    input  logic [7:0] em7,
    input  logic [7:0] em8,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       dout_sof,
    output logic       dout_eof,
    output logic       frame_fail,
    output logic [3:0] n_corr
);

    typedef enum logic [1:0] {LOAD, WAIT, OUT} state_t;

    localparam logic [7:0]    LAST_LOC = 8'(N - 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    state_t          state;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            rd_done;
    logic [7:0]      el_q [T];
    logic [7:0]      em_q [T];
    logic            fail_q;

    logic [7:0]      mem [N];
    logic [7:0]      a_data;
    logic [AW-1:0]   a_k;
    logic            a_valid;

    logic [7:0]      el_in [T];
    logic [7:0]      em_in [T];
    logic [3:0]      cnt_in;
    logic            bad_in;
    logic [7:0]      pos;
    logic [7:0]      mask;
    logic            b_load;
    logic            issue;

    always_comb begin
        el_in[0] = el1; el_in[1] = el2; el_in[2] = el3; el_in[3] = el4;
        el_in[4] = el5; el_in[5] = el6; el_in[6] = el7; el_in[7] = el8;
        em_in[0] = em1; em_in[1] = em2; em_in[2] = em3; em_in[3] = em4;
        em_in[4] = em5; em_in[5] = em6; em_in[6] = em7; em_in[7] = em8;
    end

    // Slot classification of the incoming correction set: 255 is empty,
    // anything else beyond the last byte position is a bad location.
    always_comb begin
        cnt_in = '0;
        bad_in = 1'b0;
        for (int i = 0; i < T; i++) begin
            if (el_in[i] <= LAST_LOC) cnt_in = cnt_in + 4'd1;
            else if (el_in[i] != 8'hFF) bad_in = 1'b1;
        end
    end

    // Byte k carries the coefficient of x^(N-1-k).
    always_comb begin
        pos  = LAST_LOC - 8'(a_k);
        mask = '0;
        if (!fail_q) begin
            for (int i = 0; i < T; i++) begin
                if (el_q[i] <= LAST_LOC && el_q[i] == pos) mask = mask ^ em_q[i];
            end
        end
    end

    // A read may be issued only when the read-data stage is empty or drains
    // into the output register this cycle, so no fetched byte is overwritten.
    assign b_load = a_valid && (!dout_valid || dout_ready);
    assign issue  = (state == OUT) && !rd_done && (!a_valid || b_load);

    // NOTE: the codeword buffer and its read register hold pure data qualified
    // by the pointers and a_valid, so they are deliberately left without reset.
    always_ff @(posedge clk) begin
        if (state == LOAD && din_valid) mem[wr_ptr] <= din;
        if (issue) a_data <= mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOAD;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rd_done    <= 1'b0;
            fail_q     <= 1'b0;
            for (int i = 0; i < T; i++) begin
                el_q[i] <= 8'hFF;
                em_q[i] <= 8'h00;
            end
            a_k        <= '0;
            a_valid    <= 1'b0;
            din_ready  <= 1'b1;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_sof   <= 1'b0;
            dout_eof   <= 1'b0;
            frame_fail <= 1'b0;
            n_corr     <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (din_valid) begin
                        if (wr_ptr == LAST_IDX) begin
                            wr_ptr    <= '0;
                            state     <= WAIT;
                            din_ready <= 1'b0;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (corr_valid) begin
                        for (int i = 0; i < T; i++) begin
                            el_q[i] <= el_in[i];
                            em_q[i] <= em_in[i];
                        end
                        fail_q     <= corr_fail;
                        n_corr     <= corr_fail ? 4'd0 : cnt_in;
                        frame_fail <= corr_fail | bad_in;
                        rd_ptr     <= '0;
                        rd_done    <= 1'b0;
                        state      <= OUT;
                    end
                end
                OUT: begin
                    if (dout_valid && dout_ready && dout_eof) begin
                        state     <= LOAD;
                        din_ready <= 1'b1;
                    end
                end
                default: state <= LOAD;
            endcase

            if (issue) begin
                a_k <= rd_ptr;
                if (rd_ptr == LAST_IDX) begin
                    rd_ptr  <= '0;
                    rd_done <= 1'b1;
                end else begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
            a_valid <= issue || (a_valid && !b_load);

            if (b_load) begin
                dout       <= a_data ^ mask;
                dout_valid <= 1'b1;
                dout_sof   <= (a_k == '0);
                dout_eof   <= (a_k == LAST_IDX);
            end else if (dout_ready) begin
                dout_valid <= 1'b0;
                dout_sof   <= 1'b0;
                dout_eof   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_error_corrector.sv
// Directed bench for error_corrector: a scoreboard queue is filled from a
// reference correction model when corr_valid is driven and drained per byte.
module tb_error_corrector;

    localparam int N = 204;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       corr_valid;
    logic       corr_fail;
    logic [7:0] el_v [8];
    logic [7:0] em_v [8];
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       dout_sof;
    logic       dout_eof;
    logic       frame_fail;
    logic [3:0] n_corr;

    typedef struct packed {
        logic [7:0] d;
        logic       sof;
        logic       eof;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] fr [N];
    int         compared   = 0;
    int         mismatched = 0;

    always #5 clk = ~clk;

    error_corrector #(.N(N), .T(8), .AW(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .corr_valid (corr_valid),
        .corr_fail  (corr_fail),
        .el1 (el_v[0]), .el2 (el_v[1]), .el3 (el_v[2]), .el4 (el_v[3]),
        .el5 (el_v[4]), .el6 (el_v[5]), .el7 (el_v[6]), .el8 (el_v[7]),
        .em1 (em_v[0]), .em2 (em_v[1]), .em3 (em_v[2]), .em4 (em_v[3]),
        .em5 (em_v[4]), .em6 (em_v[5]), .em7 (em_v[6]), .em8 (em_v[7]),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_sof   (dout_sof),
        .dout_eof   (dout_eof),
        .frame_fail (frame_fail),
        .n_corr     (n_corr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_slots();
        for (int i = 0; i < 8; i++) begin
            el_v[i] = 8'hFF;
            em_v[i] = 8'h00;
        end
    endtask

    task automatic fill_frame(input bit rnd);
        for (int k = 0; k < N; k++) fr[k] = rnd ? 8'($urandom) : 8'(k);
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic load_frame(input int from, input int to, input bit gaps);
        for (int k = from; k < to; k++) begin
            if (gaps && ($urandom % 4 == 0)) begin
                din_valid = 1'b0;
                @(negedge clk);
            end
            din       = fr[k];
            din_valid = 1'b1;
            @(negedge clk);
        end
        din_valid = 1'b0;
    endtask

    task automatic do_reset();
        din_valid  = 1'b0;
        corr_valid = 1'b0;
        rst_n      = 1'b0;
        #1;
        check("rst din_ready", din_ready, 1);
        check("rst dout_valid", dout_valid, 0);
        check("rst dout", dout, 0);
        check("rst sof/eof", {dout_sof, dout_eof}, 0);
        check("rst frame_fail", frame_fail, 0);
        check("rst n_corr", n_corr, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Pulses corr_valid and pushes the reference result of the current slots.
    task automatic send_corr(input bit fail);
        int         cnt = 0;
        bit         bad = 0;
        logic [7:0] d;
        corr_valid = 1'b1;
        corr_fail  = fail;
        @(negedge clk);
        corr_valid = 1'b0;
        corr_fail  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (el_v[i] < 8'(N)) cnt++;
            else if (el_v[i] != 8'hFF) bad = 1;
        end
        check("n_corr", n_corr, fail ? 0 : cnt);
        check("frame_fail", frame_fail, fail | bad);
        for (int k = 0; k < N; k++) begin
            d = fr[k];
            if (!fail) begin
                for (int i = 0; i < 8; i++)
                    if (int'(el_v[i]) == N - 1 - k) d = d ^ em_v[i];
            end
            sb.push_back('{d: d, sof: (k == 0), eof: (k == N - 1)});
        end
    endtask

    task automatic drain(input bit rnd_ready, input int n);
        int   got = 0;
        int   cycles = 0;
        bit   stalled = 0;
        exp_t prev = '0;
        exp_t e;
        while (got < n && cycles < 5000) begin
            dout_ready = rnd_ready ? ($urandom % 3 != 0) : 1'b1;
            if (stalled) begin
                check("stall valid", dout_valid, 1);
                check("stall hold", {dout, dout_sof, dout_eof}, prev);
            end
            if (dout_valid && dout_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected byte", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("dout", dout, e.d);
                    check("sof/eof", {dout_sof, dout_eof}, {e.sof, e.eof});
                end
                got++;
            end
            stalled = dout_valid && !dout_ready;
            prev    = {dout, dout_sof, dout_eof};
            @(negedge clk);
            cycles++;
        end
        check("bytes drained", got, n);
        dout_ready = 1'b1;
        if (n == N) begin
            check("post-eof dout_valid", dout_valid, 0);
            check("post-eof din_ready", din_ready, 1);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        corr_valid = 1'b0;
        corr_fail  = 1'b0;
        dout_ready = 1'b1;
        clear_slots();
        @(negedge clk);
        do_reset();

        // 1) clean frame, latency and framing
        fill_frame(0);
        load_frame(0, N, 0);
        check("din_ready after load", din_ready, 0);
        send_corr(0);
        check("latency +0", dout_valid, 0);
        @(negedge clk);
        check("latency +1", dout_valid, 0);
        @(negedge clk);
        check("latency +2", dout_valid, 1);
        drain(0, N);

        // 2) first and last byte corrected
        clear_slots();
        el_v[0] = 8'd203; em_v[0] = 8'h5A;
        el_v[1] = 8'd0;   em_v[1] = 8'h01;
        load_frame(0, N, 0);
        send_corr(0);
        check("t2 byte0", sb[0].d, 8'h5A);
        check("t2 byte203", sb[N-1].d, 8'hCA);
        drain(0, N);

        // 3) duplicate locations XOR together
        clear_slots();
        el_v[0] = 8'd10; em_v[0] = 8'hF0;
        el_v[1] = 8'd10; em_v[1] = 8'h0F;
        load_frame(0, N, 0);
        send_corr(0);
        drain(0, N);

        // 4) decoder failure, then a bad location
        clear_slots();
        el_v[0] = 8'd5; em_v[0] = 8'h33;
        load_frame(0, N, 0);
        send_corr(1);
        drain(0, N);
        el_v[2] = 8'd220; em_v[2] = 8'h77;
        load_frame(0, N, 0);
        send_corr(0);
        drain(0, N);

        // 5) random data, ignored corr_valid in LOAD, random backpressure
        fill_frame(1);
        clear_slots();
        el_v[0] = 8'd0; em_v[0] = 8'hFF;
        load_frame(0, 60, 1);
        corr_valid = 1'b1;
        corr_fail  = 1'b1;
        @(negedge clk);
        corr_valid = 1'b0;
        corr_fail  = 1'b0;
        check("corr_valid in LOAD", din_ready, 1);
        load_frame(60, N, 1);
        check("din_ready after gapped load", din_ready, 0);
        for (int i = 0; i < 8; i++) begin
            el_v[i] = (i == 7) ? 8'hFF : 8'($urandom_range(0, N - 1));
            em_v[i] = 8'($urandom);
        end
        send_corr(0);
        drain(1, N);

        // 6) reset in LOAD and in OUT, then a clean frame
        load_frame(0, 100, 0);
        do_reset();
        clear_slots();
        el_v[0] = 8'd100; em_v[0] = 8'hAA;
        el_v[1] = 8'd230; em_v[1] = 8'h11;
        load_frame(0, N, 0);
        send_corr(0);
        drain(1, 50);
        do_reset();
        el_v[1] = 8'hFF;
        load_frame(0, N, 0);
        send_corr(0);
        drain(0, N);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
